// File: rtl/axi4_stream_fifo.sv
// AXI4-Stream FIFO: a DEPTH-entry array plus a registered first-word-fall-through output beat.
// Define AXI4_STREAM_FIFO_PACKET_MODE_EN to hold output until a whole TLAST packet is stored.
module axi4_stream_fifo #(
    parameter int N     = 1,
    parameter int I     = 1,
    parameter int D     = 1,
    parameter int U     = 1,
    parameter int DEPTH = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     S_TVALID,
    output logic                     S_TREADY,
    input  logic [8*N-1:0]           S_TDATA,
    input  logic [N-1:0]             S_TSTRB,
    input  logic [N-1:0]             S_TKEEP,
    input  logic                     S_TLAST,
    input  logic [I-1:0]             S_TID,
    input  logic [D-1:0]             S_TDEST,
    input  logic [U-1:0]             S_TUSER,
    output logic                     M_TVALID,
    input  logic                     M_TREADY,
    output logic [8*N-1:0]           M_TDATA,
    output logic [N-1:0]             M_TSTRB,
    output logic [N-1:0]             M_TKEEP,
    output logic                     M_TLAST,
    output logic [I-1:0]             M_TID,
    output logic [D-1:0]             M_TDEST,
    output logic [U-1:0]             M_TUSER,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int W  = 10 * N + 1 + I + D + U;
    localparam logic [AW:0] PTR_ONE = 1;

    typedef logic [W-1:0] word_t;

    word_t          mem [DEPTH];
    word_t          s_word;
    word_t          out_q, out_d;
    logic [AW:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  count_q, count_d;
    logic           m_valid_q, m_valid_d;
    logic           s_ready_q;
    logic           push, pop, out_free, arr_empty, allow, load, mem_we;

    // Handshake: a beat moves on a rising edge only when VALID and READY are both high;
    // S_TREADY is a register, so the slave side never sees M_TREADY combinationally.
    assign s_word    = {S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER};
    assign push      = S_TVALID & s_ready_q;
    assign pop       = m_valid_q & M_TREADY;
    assign out_free  = ~m_valid_q | M_TREADY;
    assign arr_empty = (wr_q == rd_q);

`ifdef AXI4_STREAM_FIFO_PACKET_MODE_EN
    localparam int LB = I + D + U;

    logic [CW-1:0]  pkt_q, pkt_d;
    logic           mid_q, mid_d;

    // Release when a whole packet is stored (or completes this edge), while a packet is
    // already streaming, or when the array is full with no TLAST inside (deadlock escape).
    assign allow = (pkt_q != '0) | mid_q | (count_q == CW'(DEPTH)) | (push & S_TLAST);
    assign pkt_d = pkt_q + CW'(push & S_TLAST) - CW'(pop & M_TLAST);

    always_comb begin
        mid_d = mid_q;
        if (load) begin
            mid_d = ~out_d[LB];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            pkt_q <= '0;
            mid_q <= 1'b0;
        end else begin
            pkt_q <= pkt_d;
            mid_q <= mid_d;
        end
    end
`else
    assign allow = 1'b1;
`endif

    // The output register refills from the array head, or straight from the slave side
    // when the array is empty, so an idle FIFO shows a new beat one cycle after accept.
    always_comb begin
        wr_d      = wr_q;
        rd_d      = rd_q;
        out_d     = out_q;
        m_valid_d = m_valid_q;
        mem_we    = 1'b0;
        load      = out_free & allow & (~arr_empty | push);
        if (load) begin
            m_valid_d = 1'b1;
            if (!arr_empty) begin
                out_d  = mem[rd_q[AW-1:0]];
                rd_d   = rd_q + PTR_ONE;
                mem_we = push;
            end else begin
                out_d = s_word;
            end
        end else begin
            if (pop) begin
                m_valid_d = 1'b0;
            end
            mem_we = push;
        end
        if (mem_we) begin
            wr_d = wr_q + PTR_ONE;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            mem[wr_q[AW-1:0]] <= s_word;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_q      <= '0;
            rd_q      <= '0;
            out_q     <= '0;
            m_valid_q <= 1'b0;
            count_q   <= '0;
            s_ready_q <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            out_q     <= out_d;
            m_valid_q <= m_valid_d;
            count_q   <= count_d;
            s_ready_q <= (count_d != CW'(DEPTH));
        end
    end

    assign {M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER} = out_q;
    assign M_TVALID = m_valid_q;
    assign S_TREADY = s_ready_q;
    assign COUNT    = count_q;

endmodule

// File: tb/tb_axi4_stream_fifo.sv
// Self-checking bench for axi4_stream_fifo: a negedge monitor keeps an expected-beat queue and
// a beat count, checking every output beat, COUNT, S_TREADY and stall stability.
module tb_axi4_stream_fifo;

    localparam int DEPTH = 16;
    localparam int W     = 14;

    logic        ACLK, ARESET;
    logic        S_TVALID, S_TREADY;
    logic [7:0]  S_TDATA;
    logic        S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER;
    logic        M_TVALID, M_TREADY;
    logic [7:0]  M_TDATA;
    logic        M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER;
    logic [4:0]  COUNT;

    logic [W-1:0] s_word, m_word, prev_word;
    logic [W-1:0] exp_q[$];
    int           n_vec, n_err, mcount, cyc;
    logic         mon_en, stall_prev, src_done;

    axi4_stream_fifo #(.N(1), .I(1), .D(1), .U(1), .DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA), .S_TSTRB(S_TSTRB),
        .S_TKEEP(S_TKEEP), .S_TLAST(S_TLAST), .S_TID(S_TID), .S_TDEST(S_TDEST), .S_TUSER(S_TUSER),
        .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA), .M_TSTRB(M_TSTRB),
        .M_TKEEP(M_TKEEP), .M_TLAST(M_TLAST), .M_TID(M_TID), .M_TDEST(M_TDEST), .M_TUSER(M_TUSER),
        .COUNT(COUNT)
    );

    assign s_word = {S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER};
    assign m_word = {M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER};

    // clock / reset
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    always @(posedge ACLK) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [7:0] d, input logic l);
        logic [2:0] side;
        logic [1:0] sk;
        side = 3'($urandom_range(0, 7));
        sk   = 2'($urandom_range(0, 3));
        return {d, sk, l, side};
    endfunction

    // driver tasks: called at posedge+1, return at posedge+1 after the accepting edge
    task automatic send(input logic [W-1:0] w);
        logic acc;
        int   n;
        {S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER} = w;
        S_TVALID = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge ACLK);
            acc = S_TREADY;
            @(posedge ACLK);
            #1;
            n++;
        end
        chk("send_accepted", 64'(acc), 64'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        M_TREADY = 1'b1;
        while ((exp_q.size() != 0 || M_TVALID) && n < 200) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    // scoreboard / monitor: handshakes seen here happen at the following rising edge
    always @(negedge ACLK) begin
        if (mon_en) begin
            chk("count", 64'(COUNT), 64'(mcount));
            chk("s_tready", 64'(S_TREADY), 64'(mcount != DEPTH));
`ifndef AXI4_STREAM_FIFO_PACKET_MODE_EN
            chk("m_tvalid", 64'(M_TVALID), 64'(mcount != 0));
`endif
            if (stall_prev) begin
                chk("stall_valid", 64'(M_TVALID), 64'(1));
                chk("stall_payload", 64'(m_word), 64'(prev_word));
            end
            if (M_TVALID && M_TREADY) begin
                chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) chk("beat_payload", 64'(m_word), 64'(exp_q.pop_front()));
                mcount--;
            end
            if (S_TVALID && S_TREADY) begin
                exp_q.push_back(s_word);
                mcount++;
            end
            stall_prev = M_TVALID && !M_TREADY;
            prev_word  = m_word;
        end
    end

    initial begin
        int t0, t1;
        n_vec = 0; n_err = 0; mcount = 0; cyc = 0;
        mon_en = 1'b0; stall_prev = 1'b0; prev_word = '0; src_done = 1'b0;
        ARESET = 1'b1; S_TVALID = 1'b0; M_TREADY = 1'b0;
        {S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER} = '0;

        // reset state
        repeat (2) @(negedge ACLK);
        chk("reset_m_tvalid", 64'(M_TVALID), 64'(0));
        chk("reset_s_tready", 64'(S_TREADY), 64'(0));
        chk("reset_count", 64'(COUNT), 64'(0));
        chk("reset_payload", 64'(m_word), 64'(0));
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        chk("ready_after_reset", 64'(S_TREADY), 64'(1));
        mon_en = 1'b1;

        // single beat
        M_TREADY = 1'b1;
        send(mk(8'hA5, 1'b1));
        S_TVALID = 1'b0;
        @(negedge ACLK);
        chk("single_valid", 64'(M_TVALID), 64'(1));
        chk("single_data", 64'(M_TDATA), 64'(8'hA5));
        chk("single_count1", 64'(COUNT), 64'(1));
        @(negedge ACLK);
        chk("single_count0", 64'(COUNT), 64'(0));
        chk("single_gone", 64'(M_TVALID), 64'(0));
        @(posedge ACLK); #1;

        // fill to DEPTH, then release with no gaps
        M_TREADY = 1'b0;
        for (int v = 0; v < 16; v++) send(mk(8'(v), 1'b1));
        S_TVALID = 1'b0;
        @(negedge ACLK);
        chk("fill_count", 64'(COUNT), 64'(DEPTH));
        chk("fill_ready_low", 64'(S_TREADY), 64'(0));
        @(posedge ACLK); #1;
        fork
            begin
                for (int v = 16; v < 20; v++) send(mk(8'(v), 1'b1));
                S_TVALID = 1'b0;
            end
            begin
                repeat (3) begin @(posedge ACLK); #1; end
                M_TREADY = 1'b1;
                repeat (20) begin
                    @(negedge ACLK);
                    chk("fill_no_gap", 64'(M_TVALID), 64'(1));
                end
            end
        join
        drain();

        // random backpressure on both sides
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        S_TVALID = 1'b0;
                        @(posedge ACLK); #1;
                    end
                    send(mk(8'($urandom_range(0, 255)), (i == 999) ? 1'b1 : 1'($urandom_range(0, 1))));
                end
                S_TVALID = 1'b0;
                src_done = 1'b1;
            end
            begin
                while (!src_done) begin
                    M_TREADY = 1'($urandom_range(0, 1));
                    @(posedge ACLK); #1;
                end
            end
        join
        drain();

        // steady push+pop at COUNT = 8
        M_TREADY = 1'b0;
        for (int v = 0; v < 8; v++) send(mk(8'(8'h80 + v), 1'b1));
        M_TREADY = 1'b1;
        t0 = cyc;
        t1 = cyc;
        fork
            begin
                for (int i = 0; i < 100; i++) send(mk(8'(i), 1'b1));
                t1 = cyc;
            end
            begin
                repeat (100) begin
                    @(negedge ACLK);
                    chk("steady_count", 64'(COUNT), 64'(8));
                end
            end
        join
        S_TVALID = 1'b0;
        chk("steady_throughput", 64'(t1 - t0), 64'(100));
        drain();

        // asynchronous reset mid-packet with COUNT = 5
        M_TREADY = 1'b0;
        for (int v = 0; v < 5; v++) send(mk(8'(8'hC0 + v), 1'b0));
        S_TVALID = 1'b0;
        @(posedge ACLK); #2;
        mon_en = 1'b0;
        ARESET = 1'b1;
        #1;
        chk("async_rst_valid", 64'(M_TVALID), 64'(0));
        chk("async_rst_count", 64'(COUNT), 64'(0));
        chk("async_rst_payload", 64'(m_word), 64'(0));
        chk("async_rst_ready", 64'(S_TREADY), 64'(0));
        exp_q.delete();
        mcount = 0;
        stall_prev = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        chk("ready_after_async_rst", 64'(S_TREADY), 64'(1));
        mon_en = 1'b1;
        M_TREADY = 1'b1;
        send(mk(8'h3C, 1'b1));
        S_TVALID = 1'b0;
        drain();

`ifdef AXI4_STREAM_FIFO_PACKET_MODE_EN
        // packet held until its TLAST beat is accepted
        M_TREADY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(mk(8'(8'h10 + k), 1'b0));
            S_TVALID = 1'b0;
            @(negedge ACLK);
            chk("pkt_hold", 64'(M_TVALID), 64'(0));
            @(posedge ACLK); #1;
        end
        send(mk(8'h13, 1'b1));
        S_TVALID = 1'b0;
        @(negedge ACLK);
        chk("pkt_release", 64'(M_TVALID), 64'(1));
        @(posedge ACLK); #1;
        drain();

        // packet longer than DEPTH escapes instead of deadlocking
        M_TREADY = 1'b0;
        for (int k = 0; k < 16; k++) send(mk(8'(8'h40 + k), 1'b0));
        S_TVALID = 1'b0;
        repeat (2) @(negedge ACLK);
        chk("escape_valid", 64'(M_TVALID), 64'(1));
        @(posedge ACLK); #1;
        M_TREADY = 1'b1;
        for (int k = 16; k < 20; k++) send(mk(8'(8'h40 + k), (k == 19) ? 1'b1 : 1'b0));
        S_TVALID = 1'b0;
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
